// File: rtl/display_hdmi_i2c_byte_master.sv
// Byte-level I2C master for the HDMI transmitter configuration path.
// Generates START/STOP and address/data bytes, checks ACKs, and honours SCL stretching.
module display_hdmi_i2c_byte_master #(
    parameter int    SYSCLK_FREQ = 25,
    parameter string MODE        = "STANDARD"
) (
    input  logic       i_sysclk,
    input  logic       i_arstn,
    input  logic       i_m_en,
    input  logic       i_m_wr,
    input  logic       i_last,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_data,
    output logic       o_ack,
    output logic       o_last,
    output logic [7:0] o_data,
    output logic       o_nack,
    output logic       o_busy,
    input  logic       i_sda,
    output logic       o_sda_oe,
    input  logic       i_scl,
    output logic       o_scl_oe
);

    localparam int KHZ = (MODE == "FAST") ? 400 : 100;
    localparam int QTR = SYSCLK_FREQ * 1000 / (4 * KHZ);
    localparam int QW  = (QTR > 2) ? $clog2(QTR) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QTR - 1);

    if (QTR < 2) begin : g_qtr_chk
        $error("QTR below 2: raise SYSCLK_FREQ or use STANDARD mode");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WLOAD,
        S_WBYTE, S_WACK, S_RBYTE, S_RACK, S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]  qph_q, qph_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        rw_q, rw_d;
    logic        rxack_q, rxack_d;
    logic        ack_q, ack_d;
    logic        nack_q, nack_d;
    logic        last_q, last_d;
    logic        timed, stall, tick, qend, sample;
    logic        scl_oe, sda_oe;

    // Line drivers and quarter-timing strobes decoded from the current state
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        timed  = 1'b1;
        unique case (state_q)
            S_IDLE:  timed = 1'b0;
            S_START: sda_oe = 1'b1;
            S_ADDR, S_WBYTE: begin
                scl_oe = (qph_q == 2'd0);
                sda_oe = ~shreg_q[7];
            end
            S_AACK, S_WACK, S_RBYTE: scl_oe = (qph_q == 2'd0);
            S_RACK: begin
                scl_oe = (qph_q == 2'd0);
                sda_oe = ~i_last;
            end
            S_WLOAD: begin
                scl_oe = 1'b1;
                timed  = 1'b0;
            end
            S_STOP: begin
                scl_oe = (qph_q == 2'd0);
                sda_oe = (qph_q <= 2'd1);
            end
            default: timed = 1'b0;
        endcase
        stall  = timed && !scl_oe && !i_scl;
        tick   = timed && !stall && (qcnt_q == QLAST);
        qend   = tick && (qph_q == 2'd3);
        sample = tick && (qph_q == 2'd2);
    end

    // Next-state, shift register, counters and one-cycle status pulses
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        qph_d   = qph_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        rw_d    = rw_q;
        rxack_d = rxack_q;
        ack_d   = 1'b0;
        nack_d  = 1'b0;
        last_d  = 1'b0;
        if (!timed) begin
            qcnt_d = '0;
            qph_d  = 2'd0;
        end else if (!stall) begin
            if (tick) begin
                qcnt_d = '0;
                qph_d  = qph_q + 2'd1;
            end else begin
                qcnt_d = qcnt_q + QW'(1);
            end
        end
        if (sample && (state_q == S_AACK || state_q == S_WACK)) begin
            rxack_d = ~i_sda;
        end
        if (sample && state_q == S_RBYTE) begin
            shreg_d = {shreg_q[6:0], i_sda};
        end
        unique case (state_q)
            S_IDLE: begin
                if (i_m_en) begin
                    shreg_d = {i_addr, i_m_wr};
                    rw_d    = i_m_wr;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick && qph_q == 2'd1) begin
                    qph_d   = 2'd0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR, S_WBYTE: begin
                if (qend) begin
                    shreg_d = {shreg_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = (state_q == S_ADDR) ? S_AACK : S_WACK;
                    end
                end
            end
            S_AACK: begin
                if (qend) begin
                    if (!rxack_q) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        state_d = rw_q ? S_RBYTE : S_WLOAD;
                    end
                end
            end
            S_WLOAD: begin
                shreg_d = i_data;
                ack_d   = 1'b1;
                state_d = S_WBYTE;
            end
            S_WACK: begin
                if (qend) begin
                    if (!rxack_q) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        state_d = i_m_en ? S_WLOAD : S_STOP;
                    end
                end
            end
            S_RBYTE: begin
                if (qend) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        data_d  = shreg_q;
                        ack_d   = 1'b1;
                        state_d = S_RACK;
                    end
                end
            end
            S_RACK: begin
                if (qend) begin
                    state_d = (i_last || !i_m_en) ? S_STOP : S_RBYTE;
                end
            end
            S_STOP: begin
                if (qend) begin
                    last_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset releases both bus lines at once
    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            qph_q   <= 2'd0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            data_q  <= 8'h00;
            rw_q    <= 1'b0;
            rxack_q <= 1'b0;
            ack_q   <= 1'b0;
            nack_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            qph_q   <= qph_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            rw_q    <= rw_d;
            rxack_q <= rxack_d;
            ack_q   <= ack_d;
            nack_q  <= nack_d;
            last_q  <= last_d;
        end
    end

    assign o_scl_oe = scl_oe;
    assign o_sda_oe = sda_oe;
    assign o_busy   = (state_q != S_IDLE);
    assign o_ack    = ack_q;
    assign o_nack   = nack_q;
    assign o_last   = last_q;
    assign o_data   = data_q;

endmodule

// File: tb/tb_display_hdmi_i2c_byte_master.sv
// Directed bench for the HDMI I2C byte master.
// A clocked slave model on the open-drain bus answers and records bytes.
module tb_display_hdmi_i2c_byte_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_m_en = 1'b0;
    logic       i_m_wr = 1'b0;
    logic       i_last = 1'b0;
    logic [6:0] i_addr = 7'h00;
    logic [7:0] i_data = 8'h00;
    logic       o_ack, o_last, o_nack, o_busy;
    logic [7:0] o_data;
    logic       o_sda_oe, o_scl_oe;
    logic       scl, sda;
    logic       slv_scl_low = 1'b0;
    logic       slv_sda_low = 1'b0;

    int total = 0;
    int bad = 0;

    logic [7:0] wb [0:3];
    logic [7:0] got [$];
    logic       s_nack_addr = 1'b0;
    logic [7:0] s_rdata = 8'h00;
    logic [7:0] s_sreg = 8'h00;
    logic       s_mack = 1'b0;
    logic       s_rd = 1'b0;
    logic       s_in = 1'b0;
    int         s_bitn = 0;
    int         s_byten = 0;
    int         s_stops = 0;
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;
    int         cyc = 0;
    int         last_rise = 0;
    int         scl_per = 0;
    int         stop_cyc = 0;
    int         free_t = 0;

    assign scl = ~(o_scl_oe | slv_scl_low);
    assign sda = ~(o_sda_oe | slv_sda_low);

    always #5 clk = ~clk;

    display_hdmi_i2c_byte_master dut (
        .i_sysclk (clk),
        .i_arstn  (rst_n),
        .i_m_en   (i_m_en),
        .i_m_wr   (i_m_wr),
        .i_last   (i_last),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .o_ack    (o_ack),
        .o_last   (o_last),
        .o_data   (o_data),
        .o_nack   (o_nack),
        .o_busy   (o_busy),
        .i_sda    (sda),
        .o_sda_oe (o_sda_oe),
        .i_scl    (scl),
        .o_scl_oe (o_scl_oe)
    );

    // Slave model: detects START/STOP, shifts bits on SCL rise, drives on SCL fall
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        scl_p <= scl;
        sda_p <= sda;
        if (scl_p && scl && sda_p && !sda) begin
            s_in        <= 1'b1;
            s_bitn      <= 0;
            s_byten     <= 0;
            s_rd        <= 1'b0;
            s_mack      <= 1'b0;
            slv_sda_low <= 1'b0;
            free_t      <= cyc - stop_cyc;
        end else if (scl_p && scl && !sda_p && sda) begin
            s_in        <= 1'b0;
            s_stops     <= s_stops + 1;
            stop_cyc    <= cyc;
            slv_sda_low <= 1'b0;
        end else if (s_in && !scl_p && scl) begin
            if (s_bitn < 8) s_sreg <= {s_sreg[6:0], sda};
            else s_mack <= sda;
            if (s_bitn >= 1 && s_bitn <= 7) scl_per <= cyc - last_rise;
            last_rise <= cyc;
            s_bitn <= s_bitn + 1;
        end else if (s_in && scl_p && !scl) begin
            if (s_bitn == 8) begin
                if (s_byten == 0) begin
                    got.push_back(s_sreg);
                    s_rd        <= s_sreg[0];
                    slv_sda_low <= !s_nack_addr;
                end else if (!s_rd) begin
                    got.push_back(s_sreg);
                    slv_sda_low <= 1'b1;
                end else begin
                    slv_sda_low <= 1'b0;
                end
            end else if (s_bitn == 9) begin
                s_bitn      <= 0;
                s_byten     <= s_byten + 1;
                slv_sda_low <= s_rd && !s_mack && !s_rdata[7];
            end else if (s_bitn >= 1 && s_rd && s_byten > 0) begin
                slv_sda_low <= !s_rdata[3'(7 - s_bitn)];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run one transaction of nb bytes, return counts seen up to o_last
    task automatic xact(input int nb, input bit rd, input bit stretch,
                        output int busy, output int acks, output int nacks,
                        output int coll, output logic [7:0] rdat,
                        output bit tmo);
        int  left;
        bit  armed;
        bit  done;
        busy = 0; acks = 0; nacks = 0; coll = 0; rdat = 8'h00;
        tmo = 1'b1; left = 0; armed = 1'b0; done = 1'b0;
        i_m_wr = rd;
        i_data = wb[0];
        i_last = rd && (nb == 1);
        i_m_en = 1'b1;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (o_busy) busy++;
            if (int'(o_ack) + int'(o_nack) + int'(o_last) > 1) coll++;
            if (o_ack) begin
                acks++;
                rdat = o_data;
                if (!rd && acks < 4) i_data = wb[acks];
                if (acks == nb) i_m_en = 1'b0;
                if (rd && acks == nb - 1) i_last = 1'b1;
            end
            if (o_nack) nacks++;
            if (stretch && !done) begin
                if (left > 0) begin
                    left--;
                    if (left == 0) begin
                        slv_scl_low = 1'b0;
                        done = 1'b1;
                    end
                end else if (!armed && s_byten == 1 && s_bitn == 3 && o_scl_oe) begin
                    armed = 1'b1;
                end else if (armed && !o_scl_oe) begin
                    slv_scl_low = 1'b1;
                    left = 1000;
                end
            end
            if (o_last) begin
                i_m_en = 1'b0;
                tmo = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int busy, acks, nacks, coll;
        logic [7:0] rdat;
        bit tmo;
        bit seen;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_scl_oe", o_scl_oe, 0);
        chk("rst_sda_oe", o_sda_oe, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_data", o_data, 8'h00);
        chk("rst_pulses", {o_ack, o_nack, o_last}, 3'b000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // write 0x39: reg 0x41, data 0x10
        i_addr = 7'h39;
        wb[0] = 8'h41; wb[1] = 8'h10; wb[2] = 8'h00; wb[3] = 8'h00;
        xact(2, 1'b0, 1'b0, busy, acks, nacks, coll, rdat, tmo);
        chk("wr_timeout", tmo, 0);
        chk("wr_nbytes", got.size(), 3);
        chk("wr_byte0", got[0], 8'h72);
        chk("wr_byte1", got[1], 8'h41);
        chk("wr_byte2", got[2], 8'h10);
        chk("wr_acks", acks, 2);
        chk("wr_nacks", nacks, 0);
        chk("wr_stops", s_stops, 1);
        // 2 START quarters + 27 bits of 248 + 2 WLOAD + 4 STOP quarters
        chk("wr_busy_cycles", busy, 7070);
        chk("wr_scl_period", scl_per, 248);
        chk("wr_pulse_overlap", coll, 0);
        chk("wr_busy_after", o_busy, 0);
        repeat (20) @(negedge clk);

        // address NACK
        got.delete();
        s_nack_addr = 1'b1;
        xact(2, 1'b0, 1'b0, busy, acks, nacks, coll, rdat, tmo);
        s_nack_addr = 1'b0;
        chk("an_timeout", tmo, 0);
        chk("an_nacks", nacks, 1);
        chk("an_acks", acks, 0);
        chk("an_addr", got[0], 8'h72);
        chk("an_stops", s_stops, 2);
        chk("an_overlap", coll, 0);
        @(negedge clk);
        chk("an_busy_after", o_busy, 0);
        repeat (20) @(negedge clk);

        // read one byte 0xA5 with i_last
        got.delete();
        s_rdata = 8'hA5;
        xact(1, 1'b1, 1'b0, busy, acks, nacks, coll, rdat, tmo);
        chk("rd_timeout", tmo, 0);
        chk("rd_acks", acks, 1);
        chk("rd_data_at_ack", rdat, 8'hA5);
        chk("rd_addr", got[0], 8'h73);
        chk("rd_master_nack", s_mack, 1);
        chk("rd_stops", s_stops, 3);
        repeat (20) @(negedge clk);
        chk("rd_data_held", o_data, 8'hA5);

        // clock stretch of 1000 cycles in bit 3 of first data byte
        got.delete();
        xact(2, 1'b0, 1'b1, busy, acks, nacks, coll, rdat, tmo);
        chk("st_timeout", tmo, 0);
        chk("st_busy_cycles", busy, 8070);
        chk("st_byte1", got[1], 8'h41);
        chk("st_byte2", got[2], 8'h10);
        repeat (20) @(negedge clk);

        // back-to-back: enable raised again in the o_last cycle
        got.delete();
        wb[0] = 8'h41;
        xact(1, 1'b0, 1'b0, busy, acks, nacks, coll, rdat, tmo);
        chk("bb1_timeout", tmo, 0);
        wb[0] = 8'h10;
        xact(1, 1'b0, 1'b0, busy, acks, nacks, coll, rdat, tmo);
        chk("bb2_timeout", tmo, 0);
        chk("bb2_acks", acks, 1);
        chk("bb_nbytes", got.size(), 4);
        chk("bb_second_data", got[3], 8'h10);
        chk("bb_bus_free_ge_2q", free_t >= 124, 1);
        repeat (20) @(negedge clk);

        // reset in the middle of a write data byte
        wb[0] = 8'h41;
        i_m_wr = 1'b0;
        i_data = wb[0];
        i_m_en = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 5000 && !seen; n++) begin
            @(negedge clk);
            if (o_ack) seen = 1'b1;
        end
        chk("mr_wload_seen", seen, 1);
        repeat (300) @(negedge clk);
        seen = 1'b0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clk);
            if (o_scl_oe) seen = 1'b1;
        end
        chk("mr_scl_low_seen", seen, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_scl_oe", o_scl_oe, 0);
        chk("mr_sda_oe", o_sda_oe, 0);
        chk("mr_pulses", {o_ack, o_nack, o_last}, 3'b000);
        chk("mr_busy", o_busy, 0);
        chk("mr_data", o_data, 8'h00);
        i_m_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mr_idle_after", o_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
